// File: rtl/arcade_input_ctrl.sv
// Input conditioning and pause control in front of the galaga core: joystick mapping, coin pulse shaping, pause/dim.
// Latency: player inputs 2 cycles from port change; coin pulse rises 2 cycles after the port edge; pause is combinational.
// Backpressure: none; pause holds coin timing (pulses stretch, never cut) and one extra coin press is queued.
//
// Ports:
//   clk_sys, reset             - system clock, asynchronous active-high reset
//   joystick_0/1               - hps_io joystick words (bits 0-3 dirs, 4 fire, 5/6 start, 7 coin, 8 pause)
//   osd_status, osd_pause_en   - OSD open / pause-while-OSD enabled
//   hs_access                  - hiscore module pause request
//   m_up..m_fire, m_start1/2   - combined player inputs to the core
//   m_coin1/2                  - fixed-width coin pulses
//   pause, pause_toggle        - core pause, user pause state
//   dim_video                  - halve RGB intensity after a long user pause

module arcade_input_ctrl #(
    parameter int unsigned COIN_PULSE_CYCLES = 1800000,
    parameter int unsigned COIN_GAP_CYCLES   = 1800000,
    parameter logic [31:0] DIM_CYCLES        = 32'hABA9500
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic [15:0] joystick_0,
    input  logic [15:0] joystick_1,
    input  logic        osd_status,
    input  logic        osd_pause_en,
    input  logic        hs_access,
    output logic        m_up,
    output logic        m_down,
    output logic        m_left,
    output logic        m_right,
    output logic        m_fire,
    output logic        m_start1,
    output logic        m_start2,
    output logic        m_coin1,
    output logic        m_coin2,
    output logic        pause,
    output logic        pause_toggle,
    output logic        dim_video
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_PULSE = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;

    localparam logic [31:0] PULSE_LOAD = 32'(COIN_PULSE_CYCLES - 1);
    localparam logic [31:0] GAP_LOAD   = 32'(COIN_GAP_CYCLES - 1);

    // Only bits 8:0 of the joystick words carry anything this block uses.
    logic [8:0] r_joy0_q;
    logic [8:0] r_joy1_q;
    logic [8:7] r_joy0_qq;
    logic [8:7] r_joy1_qq;

    logic [8:0] w_j;
    logic       w_pause_edge;
    logic [1:0] w_coin_edge;
    logic       w_unused;

    logic       r_pause_toggle;
    logic [31:0] r_dim_cnt;
    logic       r_dim;

    logic [1:0]  r_state [2];
    logic [31:0] r_cnt   [2];
    logic [1:0]  r_pend;
    logic [1:0]  r_coin;

    assign w_unused = &{1'b0, joystick_0[15:9], joystick_1[15:9]};

    // ------------------------------------------------------------------
    // Input stage
    // ------------------------------------------------------------------
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_joy0_q  <= '0;
            r_joy1_q  <= '0;
            r_joy0_qq <= '0;
            r_joy1_qq <= '0;
        end else begin
            r_joy0_q  <= joystick_0[8:0];
            r_joy1_q  <= joystick_1[8:0];
            r_joy0_qq <= r_joy0_q[8:7];
            r_joy1_qq <= r_joy1_q[8:7];
        end
    end

    assign w_j          = r_joy0_q | r_joy1_q;
    // Pause button is shared by both players, so edge-detect the combined bit.
    assign w_pause_edge = w_j[8] & ~(r_joy0_qq[8] | r_joy1_qq[8]);
    assign w_coin_edge  = {r_joy1_q[7] & ~r_joy1_qq[7], r_joy0_q[7] & ~r_joy0_qq[7]};

    // ------------------------------------------------------------------
    // Player inputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            m_up     <= 1'b0;
            m_down   <= 1'b0;
            m_left   <= 1'b0;
            m_right  <= 1'b0;
            m_fire   <= 1'b0;
            m_start1 <= 1'b0;
            m_start2 <= 1'b0;
        end else begin
            m_up     <= w_j[3];
            m_down   <= w_j[2];
            m_left   <= w_j[1];
            m_right  <= w_j[0];
            m_fire   <= w_j[4];
            // Each pad's "select" bit acts as the other player's start.
            m_start1 <= r_joy0_q[5] | r_joy1_q[6];
            m_start2 <= r_joy1_q[5] | r_joy0_q[6];
        end
    end

    // ------------------------------------------------------------------
    // Pause
    // ------------------------------------------------------------------
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_pause_toggle <= 1'b0;
        end else if (w_pause_edge) begin
            r_pause_toggle <= ~r_pause_toggle;
        end
    end

    assign pause        = hs_access | r_pause_toggle | (osd_status & osd_pause_en);
    assign pause_toggle = r_pause_toggle;

    // ------------------------------------------------------------------
    // Dim timer: only the user toggle counts, so hiscore/OSD pauses never dim.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_dim_cnt <= '0;
            r_dim     <= 1'b0;
        end else begin
            if (!r_pause_toggle) begin
                r_dim_cnt <= '0;
            end else if (r_dim_cnt < DIM_CYCLES) begin
                r_dim_cnt <= r_dim_cnt + 32'd1;
            end
            r_dim <= (r_dim_cnt >= DIM_CYCLES);
        end
    end

    assign dim_video = r_dim;

    // ------------------------------------------------------------------
    // Coin FSMs (index 0 = coin1, 1 = coin2)
    // ------------------------------------------------------------------
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                r_state[i] <= ST_IDLE;
                r_cnt[i]   <= '0;
            end
            r_pend <= '0;
            r_coin <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                case (r_state[i])
                    ST_IDLE: begin
                        // A fresh edge starts immediately rather than waiting a cycle in pending.
                        if ((r_pend[i] || w_coin_edge[i]) && !pause) begin
                            r_pend[i]  <= 1'b0;
                            r_cnt[i]   <= PULSE_LOAD;
                            r_state[i] <= ST_PULSE;
                            r_coin[i]  <= 1'b1;
                        end else begin
                            r_pend[i] <= r_pend[i] | w_coin_edge[i];
                        end
                    end
                    ST_PULSE: begin
                        r_pend[i] <= r_pend[i] | w_coin_edge[i];
                        if (!pause) begin
                            if (r_cnt[i] == 32'd0) begin
                                r_cnt[i]   <= GAP_LOAD;
                                r_state[i] <= ST_GAP;
                                r_coin[i]  <= 1'b0;
                            end else begin
                                r_cnt[i] <= r_cnt[i] - 32'd1;
                            end
                        end
                    end
                    ST_GAP: begin
                        if (!pause && r_cnt[i] == 32'd0) begin
                            // Last gap cycle doubles as the IDLE decision for an already-queued coin,
                            // so back-to-back pulses are separated by exactly the gap length.
                            // An edge arriving now is only queued and starts from IDLE.
                            r_pend[i] <= w_coin_edge[i];
                            if (r_pend[i]) begin
                                r_cnt[i]   <= PULSE_LOAD;
                                r_state[i] <= ST_PULSE;
                                r_coin[i]  <= 1'b1;
                            end else begin
                                r_state[i] <= ST_IDLE;
                            end
                        end else begin
                            r_pend[i] <= r_pend[i] | w_coin_edge[i];
                            if (!pause) begin
                                r_cnt[i] <= r_cnt[i] - 32'd1;
                            end
                        end
                    end
                    default: begin
                        r_state[i] <= ST_IDLE;
                        r_coin[i]  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign m_coin1 = r_coin[0];
    assign m_coin2 = r_coin[1];

endmodule

// File: tb/tb_arcade_input_ctrl.sv
// Directed bench for arcade_input_ctrl with short coin/gap/dim timings.
// Cycle c is the clock period after the c-th rising edge following reset release.
// Inputs change 1 time unit after a rising edge; outputs are sampled 2 time units after it.

module tb_arcade_input_ctrl;

    logic        clk_sys = 1'b0;
    logic        reset   = 1'b1;
    logic [15:0] joystick_0 = '0;
    logic [15:0] joystick_1 = '0;
    logic        osd_status = 1'b0;
    logic        osd_pause_en = 1'b0;
    logic        hs_access = 1'b0;
    logic        m_up, m_down, m_left, m_right, m_fire;
    logic        m_start1, m_start2, m_coin1, m_coin2;
    logic        pause, pause_toggle, dim_video;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk_sys = ~clk_sys;

    arcade_input_ctrl #(
        .COIN_PULSE_CYCLES (4),
        .COIN_GAP_CYCLES   (3),
        .DIM_CYCLES        (32'd10)
    ) dut (
        .clk_sys      (clk_sys),
        .reset        (reset),
        .joystick_0   (joystick_0),
        .joystick_1   (joystick_1),
        .osd_status   (osd_status),
        .osd_pause_en (osd_pause_en),
        .hs_access    (hs_access),
        .m_up         (m_up),
        .m_down       (m_down),
        .m_left       (m_left),
        .m_right      (m_right),
        .m_fire       (m_fire),
        .m_start1     (m_start1),
        .m_start2     (m_start2),
        .m_coin1      (m_coin1),
        .m_coin2      (m_coin2),
        .pause        (pause),
        .pause_toggle (pause_toggle),
        .dim_video    (dim_video)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Leaves the bench at cycle 0 (1 unit after the first edge out of reset).
    task automatic do_reset();
        joystick_0   = '0;
        joystick_1   = '0;
        osd_status   = 1'b0;
        osd_pause_en = 1'b0;
        hs_access    = 1'b0;
        reset        = 1'b1;
        repeat (3) @(posedge clk_sys);
        #3 reset = 1'b0;
        @(posedge clk_sys);
        #1;
    endtask

    task automatic step();
        @(posedge clk_sys);
        #1;
    endtask

    // 32-cycle coin run; bit c of each mask drives/records cycle c.
    task automatic run_coin(input logic [31:0] c0m, input logic [31:0] c1m, input logic [31:0] hsm,
                            output logic [31:0] t1, output logic [31:0] t2, output logic [31:0] tp);
        t1 = '0;
        t2 = '0;
        tp = '0;
        for (int c = 0; c < 32; c++) begin
            joystick_0[7] = c0m[c];
            joystick_1[7] = c1m[c];
            hs_access     = hsm[c];
            #1;
            t1[c] = m_coin1;
            t2[c] = m_coin2;
            tp[c] = pause;
            step();
        end
        joystick_0 = '0;
        joystick_1 = '0;
        hs_access  = 1'b0;
    endtask

    function automatic logic [6:0] pad_outs();
        return {m_up, m_down, m_left, m_right, m_fire, m_start1, m_start2};
    endfunction

    logic [31:0] t1, t2, tp;
    logic        seen;

    initial begin
        // Reset state
        repeat (2) @(posedge clk_sys);
        #2;
        chk("reset_outputs",
            {20'd0, pad_outs(), m_coin1, m_coin2, pause, pause_toggle, dim_video}, 32'd0);

        // Joystick mapping: up + P2 start button -> start2
        do_reset();
        joystick_0 = 16'h0008;
        joystick_1 = 16'h0020;
        step();
        chk("map1_latency_c1", {25'd0, pad_outs()}, 32'd0);
        step();
        chk("map1_c2", {25'd0, pad_outs()}, {25'd0, 7'b1000001});
        // fire + P1 select (start2), left + P2 select (start1)
        joystick_0 = 16'h0050;
        joystick_1 = 16'h0042;
        step();
        step();
        chk("map2", {25'd0, pad_outs()}, {25'd0, 7'b0010111});
        joystick_0 = 16'h0004;
        joystick_1 = 16'h0001;
        step();
        step();
        chk("map3", {25'd0, pad_outs()}, {25'd0, 7'b0101000});

        // Single held coin1 press, coin2 pressed at cycle 4
        do_reset();
        run_coin(32'h000F_FFFF, 32'h0000_0010, 32'h0, t1, t2, tp);
        chk("coin_single_c1", t1, 32'h0000_003C);
        chk("coin_single_c2", t2, 32'h0000_03C0);
        chk("coin_single_pause", tp, 32'h0);

        // Edges at 0,2,4: second queued behind the gap, third dropped
        do_reset();
        run_coin(32'h0000_0015, 32'h0, 32'h0, t1, t2, tp);
        chk("coin_queue_c1", t1, 32'h0000_1E3C);
        chk("coin_queue_c2", t2, 32'h0);

        // hs_access pause cycles 3-7 stretches the pulse to cycles 2-10
        do_reset();
        run_coin(32'h0000_0001, 32'h0, 32'h0000_00F8, t1, t2, tp);
        chk("coin_stretch_c1", t1, 32'h0000_07FC);
        chk("coin_stretch_pause", tp, 32'h0000_00F8);

        // Edge seen on the last gap cycle starts from the following IDLE cycle
        do_reset();
        run_coin(32'h0000_0081, 32'h0, 32'h0, t1, t2, tp);
        chk("coin_gap_end_edge", t1, 32'h0000_3C3C);

        // Edge while paused is held pending until pause releases
        do_reset();
        run_coin(32'h0000_0001, 32'h0, 32'h0000_003F, t1, t2, tp);
        chk("coin_pending_pause", t1, 32'h0000_0780);

        // User pause toggle and dim timer; hs_access coincident with the first press
        do_reset();
        for (int c = 0; c < 40; c++) begin
            joystick_1[8] = (c == 0 || c == 30);
            hs_access     = (c < 2);
            #1;
            if (c == 1)  chk("toggle_c1", {31'd0, pause_toggle}, 32'd0);
            if (c == 2)  chk("toggle_c2", {30'd0, pause_toggle, pause}, 32'd3);
            if (c == 12) chk("dim_c12", {31'd0, dim_video}, 32'd0);
            if (c == 13) chk("dim_c13", {31'd0, dim_video}, 32'd1);
            if (c == 29) chk("dim_hold_c29", {31'd0, dim_video}, 32'd1);
            if (c == 31) chk("toggle_still_c31", {31'd0, pause_toggle}, 32'd1);
            if (c == 32) chk("untoggle_c32", {30'd0, pause_toggle, pause}, 32'd0);
            if (c == 34) chk("undim_c34", {31'd0, dim_video}, 32'd0);
            step();
        end
        joystick_1 = '0;
        hs_access  = 1'b0;

        // OSD pause alone pauses but never dims
        do_reset();
        osd_status   = 1'b1;
        osd_pause_en = 1'b1;
        #1;
        chk("osd_pause", {31'd0, pause}, 32'd1);
        repeat (50) step();
        chk("osd_no_dim", {30'd0, pause, dim_video}, 32'd2);
        osd_pause_en = 1'b0;
        #1;
        chk("osd_pause_disabled", {31'd0, pause}, 32'd0);
        osd_status = 1'b0;

        // Reset during a pulse with a second coin queued
        do_reset();
        joystick_0[7] = 1'b1;
        step();
        joystick_0[7] = 1'b0;
        step();
        joystick_0[7] = 1'b1;
        step();
        joystick_0[7] = 1'b0;
        step();
        chk("coin_before_reset", {31'd0, m_coin1}, 32'd1);
        reset = 1'b1;
        #1;
        chk("coin_reset_abort", {31'd0, m_coin1}, 32'd0);
        step();
        step();
        reset = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 20; c++) begin
            step();
            seen = seen | m_coin1;
        end
        chk("coin_after_reset", {31'd0, seen}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
